// File: rtl/axis_frame_arbiter_if.sv
// Bus bundle for axis_frame_arbiter: PORTS packed AXI4-Stream requesters,
// one registered AXI4-Stream output, and the current grant status.
// slave  : the arbiter's view (consumes requests, produces the output stream)
// master : the surrounding environment's view (the opposite directions)
interface axis_frame_arbiter_if #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8
);
  logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata;
  logic [PORTS-1:0]            input_axis_tvalid;
  logic [PORTS-1:0]            input_axis_tready;
  logic [PORTS-1:0]            input_axis_tlast;
  logic [PORTS-1:0]            input_axis_tuser;
  logic [DATA_WIDTH-1:0]       output_axis_tdata;
  logic                        output_axis_tvalid;
  logic                        output_axis_tready;
  logic                        output_axis_tlast;
  logic                        output_axis_tuser;
  logic [PORTS-1:0]            grant;
  logic                        grant_valid;

  modport slave (
    input  input_axis_tdata, input_axis_tvalid, input_axis_tlast, input_axis_tuser,
    output input_axis_tready,
    output output_axis_tdata, output_axis_tvalid, output_axis_tlast, output_axis_tuser,
    input  output_axis_tready,
    output grant, grant_valid
  );

  modport master (
    output input_axis_tdata, input_axis_tvalid, input_axis_tlast, input_axis_tuser,
    input  input_axis_tready,
    input  output_axis_tdata, output_axis_tvalid, output_axis_tlast, output_axis_tuser,
    output output_axis_tready,
    input  grant, grant_valid
  );
endinterface

// File: rtl/axis_frame_arbiter.sv
// Frame-granular AXI4-Stream arbiter. A grant is held from the first beat
// until the granted port's tlast beat transfers, so frames never interleave.
// The selected stream passes through a single output register stage.
// Compile-time option: define AXIS_ARB_ROUND_ROBIN_EN for round-robin
// arbitration; otherwise the lowest-index requesting port wins.
module axis_frame_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   async_rst,
  axis_frame_arbiter_if.slave    bus
);

  localparam int IDX_W = $clog2(PORTS);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t                r_state;
  logic [PORTS-1:0]      r_grant;
  logic [IDX_W-1:0]      r_gidx;
  logic                  r_grant_valid;
  logic [DATA_WIDTH-1:0] r_out_tdata;
  logic                  r_out_tvalid;
  logic                  r_out_tlast;
  logic                  r_out_tuser;
`ifdef AXIS_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]      r_rr_ptr;
  int                    w_idx_int;
`endif

  logic                  w_accept;
  logic                  w_any_req;
  logic [IDX_W-1:0]      w_win_idx;
  logic [PORTS-1:0]      w_win_onehot;
  logic [DATA_WIDTH-1:0] w_sel_tdata;
  logic                  w_sel_tvalid;
  logic                  w_sel_tlast;
  logic                  w_sel_tuser;
  logic                  w_xfer;

  // The output register can take a beat when empty or when it drains this cycle.
  assign w_accept  = bus.output_axis_tready | ~r_out_tvalid;
  assign w_any_req = |bus.input_axis_tvalid;

  // Granted-port mux, driven from the registered grant index.
  assign w_sel_tdata  = bus.input_axis_tdata[int'(r_gidx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel_tvalid = bus.input_axis_tvalid[r_gidx];
  assign w_sel_tlast  = bus.input_axis_tlast[r_gidx];
  assign w_sel_tuser  = bus.input_axis_tuser[r_gidx];

  assign w_xfer = (r_state == S_ACTIVE) & w_sel_tvalid & w_accept;

  // r_grant is zero in IDLE, so ready is only ever offered to the granted port.
  // The path from output tready to input tready is intentionally combinational.
  assign bus.input_axis_tready = r_grant & {PORTS{w_accept}};

  // Pick the winning requester for the next frame.
  always_comb begin
    w_win_idx = '0;
`ifdef AXIS_ARB_ROUND_ROBIN_EN
    w_idx_int = 0;
    // Scan downward in distance from the pointer so the nearest requester wins.
    for (int k = PORTS-1; k >= 0; k--) begin
      w_idx_int = int'(r_rr_ptr) + k;
      if (w_idx_int >= PORTS) w_idx_int = w_idx_int - PORTS;
      if (bus.input_axis_tvalid[w_idx_int]) w_win_idx = IDX_W'(w_idx_int);
    end
`else
    for (int i = PORTS-1; i >= 0; i--) begin
      if (bus.input_axis_tvalid[i]) w_win_idx = IDX_W'(i);
    end
`endif
  end

  assign w_win_onehot = PORTS'(1) << w_win_idx;

  // Frame-level FSM: latch a grant in IDLE, release it on the tlast transfer.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_gidx        <= '0;
      r_grant_valid <= 1'b0;
`ifdef AXIS_ARB_ROUND_ROBIN_EN
      r_rr_ptr      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant       <= w_win_onehot;
            r_gidx        <= w_win_idx;
            r_grant_valid <= 1'b1;
            r_state       <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (w_xfer && w_sel_tlast) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_state       <= S_IDLE;
`ifdef AXIS_ARB_ROUND_ROBIN_EN
            // Explicit wrap keeps non-power-of-two port counts in range.
            r_rr_ptr      <= (r_gidx == IDX_W'(PORTS-1)) ? '0 : r_gidx + 1'b1;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output register: load on transfer, drop valid once the held beat is taken.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_out_tdata  <= '0;
      r_out_tvalid <= 1'b0;
      r_out_tlast  <= 1'b0;
      r_out_tuser  <= 1'b0;
    end else if (w_xfer) begin
      r_out_tdata  <= w_sel_tdata;
      r_out_tvalid <= 1'b1;
      r_out_tlast  <= w_sel_tlast;
      r_out_tuser  <= w_sel_tuser;
    end else if (w_accept) begin
      r_out_tvalid <= 1'b0;
    end
  end

  assign bus.output_axis_tdata  = r_out_tdata;
  assign bus.output_axis_tvalid = r_out_tvalid;
  assign bus.output_axis_tlast  = r_out_tlast;
  assign bus.output_axis_tuser  = r_out_tuser;
  assign bus.grant              = r_grant;
  assign bus.grant_valid        = r_grant_valid;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Scoreboard bench for axis_frame_arbiter. Expected beats and grants are
// queued when a frame is scheduled; a negedge monitor pops and compares.
// Expectations that depend on the arbitration policy follow
// AXIS_ARB_ROUND_ROBIN_EN, matching the RTL build.
module tb_axis_frame_arbiter;
  localparam int PORTS = 4;
  localparam int DW    = 8;

  logic clk = 1'b0;
  logic async_rst;

  axis_frame_arbiter_if #(.PORTS(PORTS), .DATA_WIDTH(DW)) bus();

  axis_frame_arbiter #(.PORTS(PORTS), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .async_rst (async_rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] s_data  [PORTS];
  logic          s_valid [PORTS];
  logic          s_last  [PORTS];
  logic          s_user  [PORTS];

  always_comb begin
    bus.input_axis_tdata  = '0;
    bus.input_axis_tvalid = '0;
    bus.input_axis_tlast  = '0;
    bus.input_axis_tuser  = '0;
    for (int i = 0; i < PORTS; i++) begin
      bus.input_axis_tdata[i*DW +: DW] = s_data[i];
      bus.input_axis_tvalid[i]         = s_valid[i];
      bus.input_axis_tlast[i]          = s_last[i];
      bus.input_axis_tuser[i]          = s_user[i];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit abort    = 1'b0;
  bit chk_gap  = 1'b0;

  logic [DW+1:0]    exp_beats  [$];
  logic [PORTS-1:0] exp_grants [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [7:0] base, input logic [7:0] step, input int b);
    return DW'(int'(base) + int'(step) * b);
  endfunction

  // Queue a grant and the first n_seen beats of an n-beat frame.
  task automatic expect_frame(input int p, input int n, input logic [7:0] base,
                              input logic [7:0] step, input int n_seen);
    logic [DW-1:0] d;
    exp_grants.push_back(PORTS'(1) << p);
    for (int b = 0; b < n_seen; b++) begin
      d = beat_data(base, step, b);
      exp_beats.push_back({(b == n-1), d[0], d});
    end
  endtask

  // Drive one frame on port p; optional source gap after beat gap_after.
  task automatic send_frame(input int p, input int n, input logic [7:0] base,
                            input logic [7:0] step, input int gap_after, input int gap_len);
    logic [DW-1:0] d;
    bit done;
    int t;
    for (int b = 0; b < n; b++) begin
      d          = beat_data(base, step, b);
      s_data[p]  = d;
      s_user[p]  = d[0];
      s_last[p]  = (b == n-1);
      s_valid[p] = 1'b1;
      done = 1'b0;
      t    = 0;
      while (!done) begin
        @(negedge clk);
        if (abort) begin
          s_valid[p] = 1'b0;
          s_last[p]  = 1'b0;
          return;
        end
        if (bus.input_axis_tready[p]) done = 1'b1;
        t++;
        if (!done && t > 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL src_timeout: port %0d beat %0d got no ready, expected ready within 200 cycles", p, b);
          s_valid[p] = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
      if (b == gap_after && gap_len > 0) begin
        s_valid[p] = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
    end
    s_valid[p] = 1'b0;
    s_last[p]  = 1'b0;
  endtask

  task automatic two_frames(input int p);
    send_frame(p, 2, 8'(8'h81 + p*32), 8'h01, -1, 0);
    send_frame(p, 2, 8'(8'h91 + p*32), 8'h01, -1, 0);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_beats.size() != 0 || exp_grants.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    check(name, exp_beats.size() + exp_grants.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected beats on output handshakes and grants on grant rise.
  logic [PORTS-1:0] prev_grant = '0;
  int idle_cnt = 0;
  bit gap_seen = 1'b0;
  always @(negedge clk) begin
    if (async_rst) begin
      prev_grant = '0;
    end else begin
      if (bus.output_axis_tvalid && bus.output_axis_tready) begin
        if (exp_beats.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_beat: got unexpected beat 0x%0h, expected no beat", bus.output_axis_tdata);
        end else begin
          check("out_beat", {bus.output_axis_tlast, bus.output_axis_tuser, bus.output_axis_tdata},
                exp_beats.pop_front());
        end
      end
      if (bus.grant != '0 && prev_grant == '0) begin
        if (exp_grants.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL grant_order: got unexpected grant 0x%0h, expected none", bus.grant);
        end else begin
          check("grant_order", bus.grant, exp_grants.pop_front());
        end
        if (chk_gap && gap_seen) check("idle_gap", idle_cnt, 1);
        gap_seen = chk_gap;
      end
      if (bus.grant == '0) idle_cnt++;
      else idle_cnt = 0;
      prev_grant = bus.grant;
    end
  end

  initial begin
    for (int i = 0; i < PORTS; i++) begin
      s_data[i] = '0; s_valid[i] = 1'b0; s_last[i] = 1'b0; s_user[i] = 1'b0;
    end
    bus.output_axis_tready = 1'b1;
    async_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", bus.grant, 0);
    check("rst_grant_valid", bus.grant_valid, 0);
    check("rst_out_tvalid", bus.output_axis_tvalid, 0);
    check("rst_tready", bus.input_axis_tready, 0);
    check("rst_out_tdata", bus.output_axis_tdata, 0);
    async_rst = 1'b0;
    @(posedge clk);
    #1;

    // Contention: every port offers two back-to-back 2-beat frames.
`ifdef AXIS_ARB_ROUND_ROBIN_EN
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < PORTS; p++) expect_frame(p, 2, 8'(8'h81 + p*32 + f*16), 8'h01, 2);
`else
    for (int p = 0; p < PORTS; p++)
      for (int f = 0; f < 2; f++) expect_frame(p, 2, 8'(8'h81 + p*32 + f*16), 8'h01, 2);
`endif
    chk_gap = 1'b1;
    fork
      two_frames(0);
      two_frames(1);
      two_frames(2);
      two_frames(3);
    join
    chk_gap = 1'b0;
    drain("drain_contention");

    // Single frame on port 2: grant latency, output latency, release.
    expect_frame(2, 3, 8'h11, 8'h11, 3);
    fork
      send_frame(2, 3, 8'h11, 8'h11, -1, 0);
      begin
        @(negedge clk); check("sf_grant_n", bus.grant, 4'b0000);
        @(negedge clk); check("sf_grant_n1", bus.grant, 4'b0100);
        check("sf_tready_n1", bus.input_axis_tready, 4'b0100);
        @(negedge clk); check("sf_out0", {bus.output_axis_tvalid, bus.output_axis_tdata}, 9'h111);
        @(negedge clk); check("sf_out1", {bus.output_axis_tvalid, bus.output_axis_tdata}, 9'h122);
        @(negedge clk); check("sf_out2", {bus.output_axis_tvalid, bus.output_axis_tlast, bus.output_axis_tdata}, 10'h333);
        check("sf_grant_end", bus.grant, 4'b0000);
      end
    join
    drain("drain_single");

    // Wrap-around: pointer sits at 3 after port 2's frame; ports 1 and 3 request.
`ifdef AXIS_ARB_ROUND_ROBIN_EN
    expect_frame(3, 2, 8'hA0, 8'h01, 2);
    expect_frame(1, 2, 8'hB0, 8'h01, 2);
`else
    expect_frame(1, 2, 8'hB0, 8'h01, 2);
    expect_frame(3, 2, 8'hA0, 8'h01, 2);
`endif
    fork
      send_frame(3, 2, 8'hA0, 8'h01, -1, 0);
      send_frame(1, 2, 8'hB0, 8'h01, -1, 0);
    join
    drain("drain_wrap");

    // Backpressure: downstream stalls 5 cycles while beat 0x41 is held.
    expect_frame(1, 4, 8'h40, 8'h01, 4);
    fork
      send_frame(1, 4, 8'h40, 8'h01, -1, 0);
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.output_axis_tready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("bp_tvalid", bus.output_axis_tvalid, 1);
          check("bp_tdata", bus.output_axis_tdata, 8'h41);
          check("bp_tready", bus.input_axis_tready, 4'b0000);
        end
        @(posedge clk);
        #1;
        bus.output_axis_tready = 1'b1;
      end
    join
    drain("drain_bp");

    // Source gap: port 2 pauses 3 cycles mid-frame while port 1 requests.
    expect_frame(2, 4, 8'h50, 8'h01, 4);
    expect_frame(1, 2, 8'h60, 8'h01, 2);
    fork
      send_frame(2, 4, 8'h50, 8'h01, 1, 3);
      begin
        repeat (3) @(posedge clk);
        #1;
        send_frame(1, 2, 8'h60, 8'h01, -1, 0);
      end
      begin
        @(posedge clk);
        repeat (6) begin
          @(negedge clk);
          check("gap_grant", bus.grant, 4'b0100);
          check("gap_p1_tready", bus.input_axis_tready[1], 0);
        end
      end
    join
    drain("drain_gap");

    // Reset mid-frame: asserted between edges while beat 2 of 4 is on the output.
    expect_frame(3, 4, 8'hC0, 8'h01, 1);
    fork
      send_frame(3, 4, 8'hC0, 8'h01, -1, 0);
      begin
        repeat (3) @(posedge clk);
        #2;
        check("mr_pre_tdata", {bus.output_axis_tvalid, bus.output_axis_tdata}, 9'h1C1);
        #1;
        async_rst = 1'b1;
        abort     = 1'b1;
        #1;
        check("mr_out_tvalid", bus.output_axis_tvalid, 0);
        check("mr_grant", bus.grant, 0);
        check("mr_grant_valid", bus.grant_valid, 0);
        check("mr_tready", bus.input_axis_tready, 0);
        check("mr_out_tdata", bus.output_axis_tdata, 0);
        check("mr_out_tlast", bus.output_axis_tlast, 0);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    async_rst = 1'b0;
    abort     = 1'b0;
    check("mr_queue_flushed", exp_beats.size() + exp_grants.size(), 0);
    @(posedge clk);
    #1;

    // After reset the pointer restarts at 0: port 1 beats port 3 in both builds.
    expect_frame(1, 2, 8'hD0, 8'h01, 2);
    expect_frame(3, 2, 8'hE0, 8'h01, 2);
    fork
      send_frame(1, 2, 8'hD0, 8'h01, -1, 0);
      send_frame(3, 2, 8'hE0, 8'h01, -1, 0);
    join
    drain("drain_post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected finish before 200000 time units");
    $fatal(1, "global timeout");
  end

endmodule
